ddr_arbiter: RTL and testbench

Shares the single DDR3 Avalon-style port between the ROM download writer and two burst-read clients. The clients are the graphics/tile fetcher on port 0 and the frame-buffer reader on port 1. The block sits inside `Main` in the `clock` domain, between the download/read engines and the top-level `io_ddr_*` pins. It packs 16-bit download words into 64-bit masked writes, grants whole read bursts round-robin, and routes returned beats to the owning client.

---
 rtl/ddr_arbiter_pkg.sv | 18 +
 rtl/ddr_arbiter_packer.sv | 126 ++++++++++++
 rtl/ddr_arbiter.sv | 159 +++++++++++++++
 tb/tb_ddr_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arbiter_pkg.sv
// Shared types and widths for the DDR port arbiter and its download packer.
package ddr_arbiter_pkg;
    localparam int DDR_ADDR_W  = 32;
    localparam int DDR_DATA_W  = 64;
    localparam int DDR_BURST_W = 8;
    localparam int LANES       = 4;
    localparam int LANE_W      = DDR_DATA_W / LANES;
    localparam int MASK_W      = DDR_DATA_W / 8;
    localparam int DL_ADDR_W   = 25;
    localparam int TAG_W       = DL_ADDR_W - 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_CMD,
        READ_DATA
    } arb_state_t;
endpackage

// File: rtl/ddr_arbiter_packer.sv
// Packs 16-bit download words into one 64-bit masked line and raises a flush
// request when the line is full, the tag changes, or the download ends.
module dl_packer
    import ddr_arbiter_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  dl_cs,
    input  logic                  dl_wr,
    input  logic [DL_ADDR_W-1:0]  dl_addr,
    input  logic [LANE_W-1:0]     dl_data,
    input  logic                  flush_done,
    output logic                  flush_pending,
    output logic [DDR_DATA_W-1:0] din,
    output logic [MASK_W-1:0]     mask,
    output logic [TAG_W-1:0]      tag
);
    logic [DDR_DATA_W-1:0] din_q, din_d;
    logic [MASK_W-1:0]     mask_q, mask_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic                  flush_q, flush_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [LANE_W-1:0]     hold_data_q, hold_data_d;
    logic [TAG_W-1:0]      hold_tag_q, hold_tag_d;
    logic [1:0]            hold_lane_q, hold_lane_d;

    logic                  do_wr;
    logic [1:0]            wr_lane;
    logic [TAG_W-1:0]      wr_tag;
    logic [LANE_W-1:0]     wr_data;
    logic [TAG_W-1:0]      dl_tag;
    logic [1:0]            dl_lane;
    logic                  dl_addr_unused;

    assign dl_tag         = dl_addr[DL_ADDR_W-1:3];
    assign dl_lane        = dl_addr[2:1];
    assign dl_addr_unused = dl_addr[0];

    always_comb begin
        din_d        = din_q;
        mask_d       = mask_q;
        tag_d        = tag_q;
        flush_d      = flush_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_tag_d   = hold_tag_q;
        hold_lane_d  = hold_lane_q;
        do_wr        = 1'b0;
        wr_lane      = '0;
        wr_tag       = '0;
        wr_data      = '0;

        if (flush_done) begin
            din_d        = '0;
            mask_d       = '0;
            flush_d      = 1'b0;
            hold_valid_d = 1'b0;
            if (hold_valid_q) begin
                do_wr   = 1'b1;
                wr_lane = hold_lane_q;
                wr_tag  = hold_tag_q;
                wr_data = hold_data_q;
            end
        end else if (dl_wr) begin
            // A word for a different line parks in the hold register until the
            // current line has been written out.
            if ((mask_q != '0) && (dl_tag != tag_q)) begin
                hold_valid_d = 1'b1;
                hold_data_d  = dl_data;
                hold_tag_d   = dl_tag;
                hold_lane_d  = dl_lane;
                flush_d      = 1'b1;
            end else begin
                do_wr   = 1'b1;
                wr_lane = dl_lane;
                wr_tag  = dl_tag;
                wr_data = dl_data;
            end
        end

        if (do_wr) begin
            for (int k = 0; k < LANES; k++) begin
                if (wr_lane == 2'(k)) begin
                    din_d[k*LANE_W +: LANE_W] = wr_data;
                    mask_d[2*k +: 2]          = 2'b11;
                end
            end
            tag_d = wr_tag;
            if (wr_lane == 2'd3) begin
                flush_d = 1'b1;
            end
        end

        // Level check also catches a held word reloaded after dl_cs already fell.
        if (!dl_cs && (mask_d != '0)) begin
            flush_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            din_q        <= '0;
            mask_q       <= '0;
            tag_q        <= '0;
            flush_q      <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_tag_q   <= '0;
            hold_lane_q  <= '0;
        end else begin
            din_q        <= din_d;
            mask_q       <= mask_d;
            tag_q        <= tag_d;
            flush_q      <= flush_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_tag_q   <= hold_tag_d;
            hold_lane_q  <= hold_lane_d;
        end
    end

    assign flush_pending = flush_q;
    assign din           = din_q;
    assign mask          = mask_q;
    assign tag           = tag_q;
endmodule

// File: rtl/ddr_arbiter.sv
// Shares one DDR port between the download writer and two burst-read clients,
// granting whole bursts round-robin with download flushes taking priority.
module ddr_arbiter
    import ddr_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DDR_ADDR_W,
    parameter int DATA_W  = DDR_DATA_W,
    parameter int BURST_W = DDR_BURST_W
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 dl_cs,
    input  logic                 dl_wr,
    input  logic [DL_ADDR_W-1:0] dl_addr,
    input  logic [LANE_W-1:0]    dl_data,
    output logic                 dl_wait,
    input  logic                 rd0_req,
    input  logic [ADDR_W-1:0]    rd0_addr,
    input  logic [BURST_W-1:0]   rd0_len,
    output logic                 rd0_ack,
    output logic                 rd0_valid,
    input  logic                 rd1_req,
    input  logic [ADDR_W-1:0]    rd1_addr,
    input  logic [BURST_W-1:0]   rd1_len,
    output logic                 rd1_ack,
    output logic                 rd1_valid,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 ddr_rd,
    output logic                 ddr_wr,
    output logic [ADDR_W-1:0]    ddr_addr,
    output logic [BURST_W-1:0]   ddr_burst,
    output logic [7:0]           ddr_mask,
    output logic [DATA_W-1:0]    ddr_din,
    input  logic [DATA_W-1:0]    ddr_dout,
    input  logic                 ddr_waitReq,
    input  logic                 ddr_valid
);
    arb_state_t           state_q, state_d;
    logic                 grant_q, grant_d;
    logic                 last_q, last_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BURST_W-1:0]   len_q, len_d;
    logic [BURST_W-1:0]   cnt_q, cnt_d;

    logic                 flush_pending;
    logic                 flush_done;
    logic [DATA_W-1:0]    pk_din;
    logic [MASK_W-1:0]    pk_mask;
    logic [TAG_W-1:0]     pk_tag;
    logic                 pick;
    logic [BURST_W-1:0]   pick_len;

    dl_packer u_packer (
        .clock         (clock),
        .reset_n       (reset_n),
        .dl_cs         (dl_cs),
        .dl_wr         (dl_wr),
        .dl_addr       (dl_addr),
        .dl_data       (dl_data),
        .flush_done    (flush_done),
        .flush_pending (flush_pending),
        .din           (pk_din),
        .mask          (pk_mask),
        .tag           (pk_tag)
    );

    assign dl_wait = flush_pending;
    assign rd_data = ddr_dout;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        pick       = 1'b0;
        pick_len   = '0;
        flush_done = 1'b0;
        ddr_rd     = 1'b0;
        ddr_wr     = 1'b0;
        ddr_addr   = '0;
        ddr_burst  = '0;
        ddr_mask   = '0;
        ddr_din    = '0;
        rd0_ack    = 1'b0;
        rd1_ack    = 1'b0;
        rd0_valid  = 1'b0;
        rd1_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush_pending) begin
                    state_d = WRITE;
                end else if (rd0_req || rd1_req) begin
                    // On a tie the client that was not granted last time wins.
                    pick     = (rd0_req && rd1_req) ? ~last_q : rd1_req;
                    pick_len = pick ? rd1_len : rd0_len;
                    grant_d  = pick;
                    last_d   = pick;
                    addr_d   = pick ? rd1_addr : rd0_addr;
                    len_d    = (pick_len == '0) ? BURST_W'(1) : pick_len;
                    state_d  = READ_CMD;
                end
            end
            WRITE: begin
                ddr_wr    = 1'b1;
                ddr_burst = BURST_W'(1);
                ddr_addr  = ADDR_W'({pk_tag, 3'b000});
                ddr_din   = pk_din;
                ddr_mask  = pk_mask;
                if (!ddr_waitReq) begin
                    flush_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            READ_CMD: begin
                ddr_rd    = 1'b1;
                ddr_addr  = addr_q;
                ddr_burst = len_q;
                if (!ddr_waitReq) begin
                    rd0_ack = ~grant_q;
                    rd1_ack = grant_q;
                    cnt_d   = len_q;
                    state_d = READ_DATA;
                end
            end
            READ_DATA: begin
                rd0_valid = ddr_valid & ~grant_q;
                rd1_valid = ddr_valid & grant_q;
                if (ddr_valid) begin
                    cnt_d = cnt_q - BURST_W'(1);
                    if (cnt_q == BURST_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed bench for ddr_arbiter: packing, flushes, round-robin reads, stalls and reset.
module tb_ddr_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        dl_cs, dl_wr;
    logic [24:0] dl_addr;
    logic [15:0] dl_data;
    logic        dl_wait;
    logic        rd0_req, rd1_req;
    logic [31:0] rd0_addr, rd1_addr;
    logic [7:0]  rd0_len, rd1_len;
    logic        rd0_ack, rd1_ack, rd0_valid, rd1_valid;
    logic [63:0] rd_data;
    logic        ddr_rd, ddr_wr;
    logic [31:0] ddr_addr;
    logic [7:0]  ddr_burst, ddr_mask;
    logic [63:0] ddr_din, ddr_dout;
    logic        ddr_waitReq, ddr_valid;

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    ddr_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .dl_cs(dl_cs), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_wait(dl_wait),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_len(rd0_len), .rd0_ack(rd0_ack), .rd0_valid(rd0_valid),
        .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_len(rd1_len), .rd1_ack(rd1_ack), .rd1_valid(rd1_valid),
        .rd_data(rd_data), .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .ddr_addr(ddr_addr), .ddr_burst(ddr_burst),
        .ddr_mask(ddr_mask), .ddr_din(ddr_din), .ddr_dout(ddr_dout),
        .ddr_waitReq(ddr_waitReq), .ddr_valid(ddr_valid)
    );

    function automatic logic [127:0] mk(input logic w, input logic rd, input logic wr,
                                        input logic a0, input logic a1, input logic v0, input logic v1,
                                        input logic [31:0] addr, input logic [7:0] burst,
                                        input logic [7:0] mask, input logic [63:0] din);
        return {9'b0, w, rd, wr, a0, a1, v0, v1, addr, burst, mask, din};
    endfunction

    function automatic logic [127:0] outs();
        return mk(dl_wait, ddr_rd, ddr_wr, rd0_ack, rd1_ack, rd0_valid, rd1_valid,
                  ddr_addr, ddr_burst, ddr_mask, ddr_din);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the IDLE decision cycle; follows one granted burst back to IDLE.
    task automatic expect_grant(input bit port, input logic [31:0] addr, input logic [7:0] len,
                                input int beats);
        step();
        ddr_valid = 1'b1;
        ddr_dout  = 64'hDEAD;
        #1;
        chk("rd_cmd", outs(), mk(1'b0, 1'b1, 1'b0, !port, port, 1'b0, 1'b0, addr, len, 8'h0, 64'h0));
        $display("[TB] read grant port %0d addr %0h burst %0d", port, ddr_addr, ddr_burst);
        for (int b = 0; b < beats; b++) begin
            step();
            ddr_valid = 1'b1;
            ddr_dout  = {addr, 32'(b)};
            #1;
            chk("rd_beat", 128'({rd0_valid, rd1_valid, rd_data}), 128'({!port, port, addr, 32'(b)}));
        end
        step();
        #1;
        chk("rd_stray", 128'({rd0_valid, rd1_valid, ddr_rd}), 128'(3'b000));
        ddr_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        dl_cs = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        rd0_req = 1'b0; rd1_req = 1'b0; rd0_addr = '0; rd1_addr = '0; rd0_len = '0; rd1_len = '0;
        ddr_dout = '0; ddr_waitReq = 1'b0; ddr_valid = 1'b0;

        // Reset state
        repeat (3) step();
        #1;
        chk("reset_outs", outs(), 128'(0));
        reset_n = 1'b1;

        // Full-line packing
        step(); dl_cs = 1'b1; dl_wr = 1'b1; dl_addr = 25'h0; dl_data = 16'h1;
        step(); dl_addr = 25'h2; dl_data = 16'h2;
        step(); dl_addr = 25'h4; dl_data = 16'h3;
        step(); dl_addr = 25'h6; dl_data = 16'h4;
        step(); dl_wr = 1'b0; #1;
        chk("pack_wait", 128'({dl_wait, ddr_wr}), 128'(2'b10));
        step(); #1;
        chk("pack_wr", outs(), mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                  32'h0, 8'd1, 8'hFF, 64'h0004_0003_0002_0001));
        $display("[TB] write addr %0h mask %0h din %0h", ddr_addr, ddr_mask, ddr_din);
        step(); #1;
        chk("pack_done", 128'({dl_wait, ddr_wr}), 128'(2'b00));

        // Tag change flushes a partial line, then dl_cs falling flushes the held word
        step(); dl_wr = 1'b1; dl_addr = 25'h10; dl_data = 16'hA;
        step(); dl_addr = 25'h12; dl_data = 16'hB;
        step(); dl_addr = 25'h20; dl_data = 16'hC;
        step(); dl_wr = 1'b0; #1;
        chk("tag_wait", 128'({dl_wait, ddr_wr}), 128'(2'b10));
        step(); #1;
        chk("tag_wr", outs(), mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                 32'h10, 8'd1, 8'h0F, 64'h0000_0000_000B_000A));
        $display("[TB] write addr %0h mask %0h din %0h", ddr_addr, ddr_mask, ddr_din);
        step(); dl_cs = 1'b0; #1;
        chk("tag_done", 128'({dl_wait, ddr_wr}), 128'(2'b00));
        step(); #1;
        chk("cs_wait", 128'({dl_wait, ddr_wr}), 128'(2'b10));
        step(); #1;
        chk("cs_wr", outs(), mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                32'h20, 8'd1, 8'h03, 64'h0000_0000_0000_000C));
        $display("[TB] write addr %0h mask %0h din %0h", ddr_addr, ddr_mask, ddr_din);
        step(); #1;
        chk("cs_done", 128'({dl_wait, ddr_wr}), 128'(2'b00));

        // Wait-request held 5 cycles during WRITE
        step(); dl_cs = 1'b1; dl_wr = 1'b1; dl_addr = 25'h46; dl_data = 16'h1234;
        step(); dl_wr = 1'b0; ddr_waitReq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            ddr_waitReq = (i < 5);
            #1;
            chk("stall_wr", outs(), mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                       32'h40, 8'd1, 8'hC0, 64'h1234_0000_0000_0000));
        end
        $display("[TB] write addr %0h mask %0h din %0h after stall", ddr_addr, ddr_mask, ddr_din);
        step(); dl_cs = 1'b0; #1;
        chk("stall_done", 128'({dl_wait, ddr_wr}), 128'(2'b00));

        // Round-robin with both clients requesting
        step();
        rd0_req = 1'b1; rd0_addr = 32'h100; rd0_len = 8'd4;
        rd1_req = 1'b1; rd1_addr = 32'h200; rd1_len = 8'd4;
        expect_grant(1'b0, 32'h100, 8'd4, 4);
        expect_grant(1'b1, 32'h200, 8'd4, 4);
        expect_grant(1'b0, 32'h100, 8'd4, 4);
        rd0_req = 1'b0; rd1_req = 1'b0;

        // Zero length is treated as one beat
        step(); rd1_req = 1'b1; rd1_addr = 32'h600; rd1_len = 8'd0;
        expect_grant(1'b1, 32'h600, 8'd1, 1);
        rd1_req = 1'b0;

        // Flush trigger in the middle of an 8-beat burst
        step(); rd1_req = 1'b1; rd1_addr = 32'h300; rd1_len = 8'd8;
        step(); #1;
        chk("wb_cmd", outs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 8'd8, 8'h0, 64'h0));
        for (int b = 0; b < 8; b++) begin
            step();
            rd1_req   = 1'b0;
            ddr_valid = 1'b1;
            ddr_dout  = 64'(b);
            dl_wr     = (b == 2);
            if (b == 2) begin
                dl_cs   = 1'b1;
                dl_addr = 25'h86;
                dl_data = 16'h7777;
            end
            #1;
            chk("wb_beat", 128'({rd1_valid, ddr_wr, dl_wait}), 128'({1'b1, 1'b0, (b >= 3)}));
        end
        step(); ddr_valid = 1'b0; #1;
        chk("wb_idle", 128'({ddr_rd, ddr_wr, dl_wait, rd1_valid}), 128'(4'b0010));
        step(); #1;
        chk("wb_wr", outs(), mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                32'h80, 8'd1, 8'hC0, 64'h7777_0000_0000_0000));
        $display("[TB] write addr %0h mask %0h din %0h after burst", ddr_addr, ddr_mask, ddr_din);
        step(); dl_cs = 1'b0; #1;
        chk("wb_done", 128'({dl_wait, ddr_wr}), 128'(2'b00));

        // Reset asserted mid READ_DATA
        step(); rd0_req = 1'b1; rd0_addr = 32'h400; rd0_len = 8'd4;
        step(); #1;
        chk("rst_cmd", outs(), mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 8'd4, 8'h0, 64'h0));
        step(); rd0_req = 1'b0; ddr_valid = 1'b1; ddr_dout = 64'h55; #1;
        chk("rst_beat", 128'({rd0_valid, rd1_valid}), 128'(2'b10));
        step(); reset_n = 1'b0; #1;
        chk("rst_mid", outs(), 128'(0));
        $display("[TB] reset asserted during read burst");
        step();
        step(); reset_n = 1'b1; ddr_valid = 1'b0;
        rd0_req = 1'b1; rd0_addr = 32'h500; rd0_len = 8'd2;
        rd1_req = 1'b1; rd1_addr = 32'h580; rd1_len = 8'd2;
        expect_grant(1'b0, 32'h500, 8'd2, 2);
        rd0_req = 1'b0; rd1_req = 1'b0;
        step(); #1;
        chk("final_idle", outs(), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
